// File: rtl/ccff_bitstream_loader_if.sv
// Configuration word channel between a bitstream source and the loader.
//   cfg_data/cfg_valid/cfg_ready : configuration words in (valid/ready)
//   rb_data/rb_valid             : readback words out (one-cycle pulse)
// master = bitstream source / readback sink, slave = loader.
interface ccff_bitstream_loader_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;

    modport master (
        output cfg_data, cfg_valid,
        input  cfg_ready, rb_data, rb_valid
    );

    modport slave (
        input  cfg_data, cfg_valid,
        output cfg_ready, rb_data, rb_valid
    );
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Feeds a configuration flip-flop chain (ccff_head -> ... -> ccff_tail).
// Words arrive on the cfg channel and are shifted MSB-first for exactly
// CHAIN_LEN bits; ccff_shift_en drives an external clock gate so the chain
// only advances on shifting cycles. Bits returning on ccff_tail are packed
// into readback words (right-aligned, zero-padded for a partial last word).
// Ports:
//   prog_clk, prog_rst_n : clock, async active-low reset
//   start, abort         : begin a load (IDLE/DONE only) / return to IDLE
//   cfg                  : word channel (slave side)
//   ccff_head            : serial data into the chain (registered)
//   ccff_shift_en        : chain clock-gate enable for the current cycle
//   ccff_tail            : serial data out of the chain
//   busy, done           : in WAIT_WORD/SHIFT, held in DONE
module ccff_bitstream_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                     prog_clk,
    input  logic                     prog_rst_n,
    input  logic                     start,
    input  logic                     abort,
    ccff_bitstream_loader_if.slave   cfg,
    output logic                     ccff_head,
    output logic                     ccff_shift_en,
    input  logic                     ccff_tail,
    output logic                     busy,
    output logic                     done
);
    localparam int WL_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WL_W-1:0]   word_left;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] rbreg;

    logic [CNT_W-1:0]  remaining;
    logic [WORD_W-1:0] sh_next;
    logic [WORD_W-1:0] rb_next;

    // Bits still owed to the chain; caps the last word when partial.
    assign remaining = CNT_W'(CHAIN_LEN) - bit_cnt;
    assign sh_next   = shreg << 1;
    assign rb_next   = (rbreg << 1) | WORD_W'(ccff_tail);

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            word_left     <= '0;
            shreg         <= '0;
            rbreg         <= '0;
            cfg.cfg_ready <= 1'b0;
            cfg.rb_data   <= '0;
            cfg.rb_valid  <= 1'b0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            cfg.rb_valid <= 1'b0;
            if (abort) begin
                // Chain contents become undefined; no readback for the
                // interrupted word.
                state         <= IDLE;
                cfg.cfg_ready <= 1'b0;
                ccff_head     <= 1'b0;
                ccff_shift_en <= 1'b0;
                busy          <= 1'b0;
                done          <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state         <= WAIT_WORD;
                            bit_cnt       <= '0;
                            cfg.cfg_ready <= 1'b1;
                            busy          <= 1'b1;
                            done          <= 1'b0;
                        end
                    end
                    WAIT_WORD: begin
                        if (cfg.cfg_valid) begin
                            shreg         <= cfg.cfg_data;
                            ccff_head     <= cfg.cfg_data[WORD_W-1];
                            rbreg         <= '0;
                            word_left     <= (int'(remaining) < WORD_W) ?
                                             WL_W'(remaining) : WL_W'(WORD_W);
                            cfg.cfg_ready <= 1'b0;
                            ccff_shift_en <= 1'b1;
                            state         <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        // The chain captures ccff_head on this same edge.
                        shreg     <= sh_next;
                        ccff_head <= sh_next[WORD_W-1];
                        rbreg     <= rb_next;
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                        word_left <= word_left - WL_W'(1);
                        if (word_left == WL_W'(1)) begin
                            ccff_shift_en <= 1'b0;
                            ccff_head     <= 1'b0;
                            cfg.rb_valid  <= 1'b1;
                            cfg.rb_data   <= rb_next;
                            if (bit_cnt == CNT_W'(CHAIN_LEN - 1)) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state         <= WAIT_WORD;
                                cfg.cfg_ready <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
